rom_port_arbiter: RTL

- Shares the single-port 32 KB firmware ROM between the CPU instruction-fetch port and the data-bus ROM window.
- Replaces the combinational ibus-first mux with a registered, starvation-bounded arbiter.
- Keeps one ROM transaction in flight and routes data and ack back to the owning requester.
- Sits between the CPU/interconnect and rom_32kb in the SoC top level.

---
 rtl/rom_arb_pkg.sv | 23 ++
 rtl/rom_arb_starve_ctr.sv | 34 +++
 rtl/rom_port_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the firmware-ROM port arbiter.
//   state_t : arbiter FSM encoding (IDLE, BUSY_I, BUSY_D, RESP)
//   owner_t : which requester owns the in-flight ROM transaction
//   MAX_STALL_DEFAULT : default ibus grants allowed while dbus waits
//   STARVE_W : width of the starvation counter (covers MAX_STALL 1..15)
package rom_arb_pkg;

  localparam int unsigned MAX_STALL_DEFAULT = 4;
  localparam int unsigned STARVE_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/rom_arb_starve_ctr.sv
// rom_arb_starve_ctr: saturating count of ibus grants taken while dbus waited.
// Ports:
//   clk_100mhz, rst_n : clock, async active-low reset
//   inc               : ibus granted while dbus was requesting
//   clr               : dbus granted
//   force_d_c         : counter saturated, dbus must win the next contest
module rom_arb_starve_ctr
  import rom_arb_pkg::*;
#(
  parameter int unsigned MAX_STALL = MAX_STALL_DEFAULT
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic force_d_c
);

  logic [STARVE_W-1:0] starve_cnt;

  assign force_d_c = (starve_cnt == STARVE_W'(MAX_STALL));

  // Clear wins over increment; increment stops at MAX_STALL.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (clr) begin
      starve_cnt <= '0;
    end else if (inc && !force_d_c) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single-port firmware ROM between the CPU
// instruction fetch port (ibus) and the data-bus ROM window (dbus).
// One ROM transaction is in flight at a time; ibus wins contests unless dbus
// has been passed over MAX_STALL times in a row.
// Ports:
//   clk_100mhz, rst_n          : clock, async active-low reset
//   ibus_cyc/stb/addr          : fetch request;   ibus_ack/dat : fetch response
//   dbus_stb/addr              : data request;    dbus_ack/dat : data response
//   rom_addr/stb               : registered ROM request
//   rom_data/ack               : ROM response
//   err                        : timeout abort pulse
// Optional build macro: ROM_ARB_TIMEOUT_EN (abort BUSY after TIMEOUT cycles
// without rom_ack; otherwise err is tied low and BUSY waits indefinitely).
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_STALL = MAX_STALL_DEFAULT,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk_100mhz,
  input  logic              rst_n,
  input  logic              ibus_cyc,
  input  logic              ibus_stb,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic              ibus_ack,
  output logic [DATA_W-1:0] ibus_dat,
  input  logic              dbus_stb,
  input  logic [ADDR_W-1:0] dbus_addr,
  output logic              dbus_ack,
  output logic [DATA_W-1:0] dbus_dat,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_stb,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_ack,
  output logic              err
);

  state_t state;
  owner_t owner;

  logic ireq_c;
  logic dreq_c;
  logic force_d_c;
  logic grant_i_c;
  logic grant_d_c;
  logic starve_inc_c;
  logic starve_clr_c;
  logic owner_req_c;
  logic timeout_c;

  // Out-of-range configuration shows up as this block in the hierarchy.
  if ((MAX_STALL < 1) || (MAX_STALL > 15) || (TIMEOUT < 2)) begin : g_param_range_error
  end

  // Request decode and IDLE arbitration.
  always_comb begin
    ireq_c    = ibus_cyc & ibus_stb;
    dreq_c    = dbus_stb;
    grant_i_c = 1'b0;
    grant_d_c = 1'b0;
    if (state == IDLE) begin
      grant_d_c = dreq_c & (~ireq_c | force_d_c);
      grant_i_c = ireq_c & ~grant_d_c;
    end
    starve_inc_c = grant_i_c & dreq_c;
    starve_clr_c = grant_d_c;
    owner_req_c  = (owner == OWN_I) ? ireq_c : dreq_c;
  end

  rom_arb_starve_ctr #(
    .MAX_STALL (MAX_STALL)
  ) u_starve (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .inc        (starve_inc_c),
    .clr        (starve_clr_c),
    .force_d_c  (force_d_c)
  );

  // Arbiter FSM with registered ROM request, data capture and ack routing.
  // The ack is registered on the rom_ack edge so it is high during RESP; a
  // requester that has withdrawn by then gets neither ack nor data.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_I;
      rom_addr <= '0;
      rom_stb  <= 1'b0;
      ibus_ack <= 1'b0;
      dbus_ack <= 1'b0;
      ibus_dat <= '0;
      dbus_dat <= '0;
    end else begin
      ibus_ack <= 1'b0;
      dbus_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i_c) begin
            state    <= BUSY_I;
            owner    <= OWN_I;
            rom_addr <= ibus_addr;
            rom_stb  <= 1'b1;
          end else if (grant_d_c) begin
            state    <= BUSY_D;
            owner    <= OWN_D;
            rom_addr <= dbus_addr;
            rom_stb  <= 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (rom_ack) begin
            rom_stb <= 1'b0;
            state   <= RESP;
            if (owner_req_c) begin
              if (owner == OWN_I) begin
                ibus_dat <= rom_data;
                ibus_ack <= 1'b1;
              end else begin
                dbus_dat <= rom_data;
                dbus_ack <= 1'b1;
              end
            end
          end else if (timeout_c) begin
            rom_stb <= 1'b0;
            state   <= IDLE;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ROM_ARB_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  logic [TCNT_W-1:0] tcnt;
  logic              busy_c;

  assign busy_c    = (state == BUSY_I) || (state == BUSY_D);
  assign timeout_c = busy_c && !rom_ack && (tcnt == TCNT_W'(TIMEOUT - 1));

  // Counts BUSY cycles; cleared whenever the FSM is outside BUSY.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      err  <= timeout_c;
      tcnt <= (busy_c && !timeout_c) ? tcnt + TCNT_W'(1) : '0;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
